// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage RV32I core.
// Optional bubble counters (perf_lu_bubbles, perf_flush_bubbles) are enabled by defining ID_EX_PERF_EN.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [1:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              ex_valid,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       perf_lu_bubbles,
  output logic [31:0]       perf_flush_bubbles,
`endif
  output logic              stall_o
);

  logic load_use;
  logic rd_hit;
  logic bubble;

  // rs2 only matters when the ID instruction actually reads it (R-type or store data)
  always_comb begin
    rd_hit   = (ex_rd == id_rs1) ||
               ((ex_rd == id_rs2) && (!id_alu_src || id_mem_write));
    load_use = ex_valid && ex_mem_read && (ex_rd != '0) && rd_hit && id_valid;
    stall_o  = hold_i || (load_use && !flush_i);
    bubble   = flush_i || load_use;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_alu_op     <= '0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= '0;
      ex_funct7     <= '0;
    end else if (hold_i) begin
      ex_valid <= ex_valid;
    end else if (bubble) begin
      // Data fields clear too so forwarding never sees stale operands
      ex_valid      <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_alu_op     <= '0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= '0;
      ex_funct7     <= '0;
    end else begin
      ex_valid      <= id_valid;
      ex_alu_src    <= id_alu_src;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_branch     <= id_branch;
      ex_jump       <= id_jump;
      ex_alu_op     <= id_alu_op;
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_funct3     <= id_funct3;
      ex_funct7     <= id_funct7;
    end
  end

`ifdef ID_EX_PERF_EN
  // Flush takes priority, so a coincident load-use is counted as a flush bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_bubbles    <= '0;
      perf_flush_bubbles <= '0;
    end else if (!hold_i) begin
      if (flush_i) begin
        perf_flush_bubbles <= 32'(perf_flush_bubbles + 32'd1);
      end else if (load_use) begin
        perf_lu_bubbles <= 32'(perf_lu_bubbles + 32'd1);
      end
    end
  end
`endif

endmodule
